// File: rtl/ahb_bus_arbiter_if.sv
// Arbitration-side AHB signals shared by the masters' request logic and the bus arbiter.
// The master modport is the requesting side; the slave modport is the arbiter's view.
interface ahb_bus_arbiter_if #(
    parameter int MASTER_NUM = 4
);
    logic [MASTER_NUM-1:0] hbusreq;
    logic [MASTER_NUM-1:0] hlock;
    logic [1:0]            htrans;
    logic [2:0]            hburst;
    logic                  hready;
    logic [MASTER_NUM-1:0] hgrant;
    logic [3:0]            hmaster;
    logic                  hmastlock;

    modport master (
        output hbusreq, hlock, htrans, hburst, hready,
        input  hgrant, hmaster, hmastlock
    );

    modport slave (
        input  hbusreq, hlock, htrans, hburst, hready,
        output hgrant, hmaster, hmastlock
    );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB bus arbiter for up to 16 masters, holding the bus through
// fixed-length bursts and locked sequences; all outputs are registered.
module ahb_bus_arbiter #(
    parameter int MASTER_NUM     = 4,
    parameter int DEFAULT_MASTER = MASTER_NUM - 1
) (
    input  logic             hclk,
    input  logic             hreset,
    ahb_bus_arbiter_if.slave bus
);
    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;
    localparam logic [MASTER_NUM-1:0] GRANT_ONE = {{(MASTER_NUM-1){1'b0}}, 1'b1};
    localparam logic [3:0] DEFAULT_IDX = 4'(DEFAULT_MASTER);

    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_BURST  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    state_e                state_q;
    logic [3:0]            cnt_q;
    logic [3:0]            rr_ptr_q;
    logic [3:0]            hmaster_q;
    logic [MASTER_NUM-1:0] hgrant_q;
    logic                  hmastlock_q;

    logic [3:0] owner_idx_s;
    logic [3:0] rr_win_s;
    logic       rr_found_s;
    logic       owner_lock_s;
    logic       win_lock_s;
    logic       arb_s;
    logic       burst_start_s;

    function automatic logic bit_at(input logic [MASTER_NUM-1:0] vec, input logic [3:0] idx);
        logic [MASTER_NUM-1:0] shifted;
        shifted = vec >> idx;
        return shifted[0];
    endfunction

    function automatic logic [3:0] grant_index(input logic [MASTER_NUM-1:0] grant);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            idx = bit_at(grant, 4'(i)) ? 4'(i) : idx;
        end
        return idx;
    endfunction

    function automatic logic [3:0] rr_cand(input logic [3:0] ptr, input int k);
        return 4'((int'(ptr) + k) % MASTER_NUM);
    endfunction

    // Counter load value is the number of SEQ beats still to come after the NONSEQ.
    function automatic logic [3:0] burst_seq_beats(input logic [2:0] burst);
        case (burst)
            3'd2, 3'd3: return 4'd3;
            3'd4, 3'd5: return 4'd7;
            3'd6, 3'd7: return 4'd15;
            default:    return 4'd0;
        endcase
    endfunction

    // Round-robin winner: scan offsets from the far end so the nearest requester after the pointer wins.
    always_comb begin
        rr_win_s = DEFAULT_IDX;
        for (int k = MASTER_NUM; k >= 1; k--) begin
            rr_win_s = bit_at(bus.hbusreq, rr_cand(rr_ptr_q, k)) ? rr_cand(rr_ptr_q, k) : rr_win_s;
        end
        rr_found_s = |bus.hbusreq;
    end

    // Decide whether this cycle re-arbitrates or opens a fixed-length burst.
    always_comb begin
        owner_idx_s   = grant_index(hgrant_q);
        owner_lock_s  = bit_at(bus.hlock, owner_idx_s);
        win_lock_s    = bit_at(bus.hlock, rr_win_s);
        arb_s         = 1'b0;
        burst_start_s = 1'b0;
        if (bus.hready) begin
            case (state_q)
                ST_ARB: begin
                    if ((bus.htrans == HTRANS_NONSEQ) && (bus.hburst >= 3'd2)) begin
                        burst_start_s = 1'b1;
                    end else begin
                        arb_s = 1'b1;
                    end
                end
                ST_BURST: begin
                    if (((bus.htrans == HTRANS_SEQ) && (cnt_q == 4'd1)) ||
                        (bus.htrans == HTRANS_IDLE) || (bus.htrans == HTRANS_NONSEQ)) begin
                        arb_s = 1'b1;
                    end else begin
                        arb_s = 1'b0;
                    end
                end
                ST_LOCKED: arb_s = ~owner_lock_s;
                default:   arb_s = 1'b1;
            endcase
        end else begin
            arb_s = 1'b0;
        end
    end

    // Grant/ownership FSM; a stalled bus freezes every register.
    always_ff @(posedge hclk or negedge hreset) begin
        if (!hreset) begin
            state_q     <= ST_ARB;
            cnt_q       <= 4'd0;
            rr_ptr_q    <= DEFAULT_IDX;
            hgrant_q    <= GRANT_ONE << DEFAULT_IDX;
            hmaster_q   <= DEFAULT_IDX;
            hmastlock_q <= 1'b0;
        end else if (bus.hready) begin
            hmaster_q   <= owner_idx_s;
            hmastlock_q <= owner_lock_s;
            if (arb_s) begin
                hgrant_q <= GRANT_ONE << rr_win_s;
                if (rr_found_s) begin
                    rr_ptr_q <= rr_win_s;
                end
                state_q <= win_lock_s ? ST_LOCKED : ST_ARB;
                cnt_q   <= 4'd0;
            end else if (burst_start_s) begin
                state_q <= ST_BURST;
                cnt_q   <= burst_seq_beats(bus.hburst);
            end else if ((state_q == ST_BURST) && (bus.htrans == HTRANS_SEQ)) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    assign bus.hgrant    = hgrant_q;
    assign bus.hmaster   = hmaster_q;
    assign bus.hmastlock = hmastlock_q;
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scoreboard bench for ahb_bus_arbiter: directed scenarios followed by random traffic,
// expected outputs produced by a behavioural round-robin/burst/lock model.
module tb_ahb_bus_arbiter;
    localparam int N   = 4;
    localparam int DEF = N - 1;

    localparam int MODE_FREE   = 0;
    localparam int MODE_BURST  = 1;
    localparam int MODE_LOCKED = 2;

    logic hclk   = 1'b0;
    logic hreset = 1'b1;

    ahb_bus_arbiter_if #(.MASTER_NUM(N)) bus ();

    ahb_bus_arbiter #(.MASTER_NUM(N), .DEFAULT_MASTER(DEF)) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        logic [N-1:0] grant;
        logic [3:0]   master;
        logic         mlock;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;

    // Reference model state, expressed as indices and a remaining-beat count.
    int m_grant, m_master, m_last, m_mode, m_left;
    bit m_mlock;

    function automatic bit bit_of(input logic [N-1:0] v, input int idx);
        logic [N-1:0] sh;
        sh = v >> idx;
        return sh[0];
    endfunction

    function automatic int rr_pick(input logic [N-1:0] req);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_last + k) % N;
            if (bit_of(req, idx)) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_grant  = DEF;
        m_master = DEF;
        m_last   = DEF;
        m_mode   = MODE_FREE;
        m_left   = 0;
        m_mlock  = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] req, input logic [N-1:0] lk,
                              input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
        bit rearb;
        int w;
        if (!rdy) return;
        rearb = 1'b0;
        if (m_mode == MODE_FREE) begin
            if (tr == 2'd2 && bu >= 3'd2) begin
                m_mode = MODE_BURST;
                m_left = (4 << ((int'(bu) / 2) - 1)) - 1;
            end else begin
                rearb = 1'b1;
            end
        end else if (m_mode == MODE_BURST) begin
            if (tr == 2'd3) begin
                if (m_left == 1) rearb = 1'b1;
                else m_left = m_left - 1;
            end else if (tr != 2'd1) begin
                rearb = 1'b1;
            end
        end else begin
            if (!bit_of(lk, m_grant)) rearb = 1'b1;
        end
        m_master = m_grant;
        m_mlock  = bit_of(lk, m_grant);
        if (rearb) begin
            w = rr_pick(req);
            if (w < 0) w = DEF;
            else m_last = w;
            m_grant = w;
            m_mode  = bit_of(lk, w) ? MODE_LOCKED : MODE_FREE;
            m_left  = 0;
        end
    endtask

    task automatic push_expected();
        exp_t e;
        logic [N-1:0] one;
        one      = 1;
        e.grant  = one << m_grant;
        e.master = 4'(m_master);
        e.mlock  = m_mlock;
        e.cyc    = cyc;
        exp_q.push_back(e);
    endtask

    // One bus cycle: drive inputs just after the edge, record what the DUT must show until the next edge.
    task automatic cycle(input logic [N-1:0] req, input logic [N-1:0] lk, input logic [1:0] tr,
                         input logic [2:0] bu, input logic rdy, input logic rst_n);
        hreset      = rst_n;
        bus.hbusreq = req;
        bus.hlock   = lk;
        bus.htrans  = tr;
        bus.hburst  = bu;
        bus.hready  = rdy;
        if (!rst_n) model_reset();
        push_expected();
        if (rst_n) model_step(req, lk, tr, bu, rdy);
        @(posedge hclk);
        #1;
        cyc++;
    endtask

    // Monitor: compare outputs against the scoreboard away from the active edge.
    always @(negedge hclk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_total++;
            if (bus.hgrant === e.grant) n_pass++;
            else $display("FAIL hgrant cyc=%0d got=%b exp=%b", e.cyc, bus.hgrant, e.grant);
            n_total++;
            if (bus.hmaster === e.master) n_pass++;
            else $display("FAIL hmaster cyc=%0d got=%0d exp=%0d", e.cyc, bus.hmaster, e.master);
            n_total++;
            if (bus.hmastlock === e.mlock) n_pass++;
            else $display("FAIL hmastlock cyc=%0d got=%b exp=%b", e.cyc, bus.hmastlock, e.mlock);
            n_total++;
            if ($onehot(bus.hgrant)) n_pass++;
            else $display("FAIL onehot cyc=%0d got=%b exp=one-hot", e.cyc, bus.hgrant);
        end
    end

    initial begin
        logic [N-1:0] rq, lk;
        logic [1:0]   tr;
        bus.hbusreq = '0;
        bus.hlock   = '0;
        bus.htrans  = 2'd0;
        bus.hburst  = 3'd0;
        bus.hready  = 1'b1;
        model_reset();
        #2 hreset = 1'b0;
        @(posedge hclk);
        #1;

        // Reset held, then idle with no requests.
        for (int i = 0; i < 3; i++) cycle(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cycle(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b1);

        // Round-robin rotation with all masters requesting SINGLE transfers.
        for (int i = 0; i < 6; i++) cycle(4'b1111, 4'b0000, 2'd2, 3'd0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cycle(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b1);

        // Fixed INCR4 by master 1 with a BUSY and a wait state while master 2 requests.
        cycle(4'b0010, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b1);
        cycle(4'b0010, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b1);
        cycle(4'b0110, 4'b0000, 2'd2, 3'd3, 1'b1, 1'b1);
        cycle(4'b0110, 4'b0000, 2'd3, 3'd3, 1'b1, 1'b1);
        cycle(4'b0110, 4'b0000, 2'd1, 3'd3, 1'b1, 1'b1);
        cycle(4'b0110, 4'b0000, 2'd3, 3'd3, 1'b0, 1'b1);
        cycle(4'b0110, 4'b0000, 2'd3, 3'd3, 1'b1, 1'b1);
        cycle(4'b0110, 4'b0000, 2'd3, 3'd3, 1'b1, 1'b1);
        cycle(4'b0100, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b1);

        // INCR8 by master 0 terminated early with IDLE while master 3 requests.
        cycle(4'b0001, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b1);
        cycle(4'b0001, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b1);
        cycle(4'b1001, 4'b0000, 2'd2, 3'd5, 1'b1, 1'b1);
        cycle(4'b1001, 4'b0000, 2'd3, 3'd5, 1'b1, 1'b1);
        cycle(4'b1001, 4'b0000, 2'd0, 3'd5, 1'b1, 1'b1);
        cycle(4'b1000, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b1);

        // Locked sequence by master 2 against competing requests, then release.
        cycle(4'b0100, 4'b0100, 2'd0, 3'd0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) cycle(4'b0111, 4'b0100, 2'd2, 3'd3, 1'b1, 1'b1);
        cycle(4'b0011, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b1);
        cycle(4'b0001, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b1);

        // Reset asserted in the middle of an INCR16.
        cycle(4'b0001, 4'b0000, 2'd2, 3'd7, 1'b1, 1'b1);
        cycle(4'b0001, 4'b0000, 2'd3, 3'd7, 1'b1, 1'b1);
        cycle(4'b0001, 4'b0000, 2'd3, 3'd7, 1'b1, 1'b0);
        cycle(4'b0001, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b0);
        cycle(4'b0001, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b1);
        cycle(4'b0001, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b1);

        // Random traffic biased toward SEQ beats so bursts can run to completion.
        for (int i = 0; i < 800; i++) begin
            rq = 4'($urandom);
            lk = 4'($urandom) & 4'($urandom) & 4'($urandom);
            tr = ($urandom_range(0, 7) < 5) ? 2'd3 : 2'($urandom_range(0, 2));
            cycle(rq, lk, tr, 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 199) != 0));
        end

        @(negedge hclk);
        #1;
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ahb_bus_arbiter.md
# ahb_bus_arbiter

Multi-master AHB arbiter that shares one AHB-Lite slave-side bus between up to 16 masters. It samples per-master bus requests and lock requests, issues a one-hot registered `hgrant` and drives `hmaster`/`hmastlock` for the address phase. Each granted fixed-length burst and each locked sequence completes before the bus is handed over. It sits between the master request interfaces and the address/data multiplexers, which select on `hmaster`.

## Interface
- `MASTER_NUM`, default 4: number of masters, legal range 2..16.
- `DEFAULT_MASTER`, default `MASTER_NUM-1`: index granted when no master requests.
- `hclk` input 1: bus clock; all state updates on the rising edge.
- `hreset` input 1: reset, asynchronous, active-low.
- `hbusreq` input `MASTER_NUM`: bus request, bit i from master i.
- `hlock` input `MASTER_NUM`: locked-access request, bit i from master i.
- `htrans` input 2: transfer type of the current address-phase master (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- `hburst` input 3: burst type of the current address-phase master (SINGLE=0, INCR=1, WRAP4/INCR4=2/3, WRAP8/INCR8=4/5, WRAP16/INCR16=6/7).
- `hready` input 1: bus ready from the slave mux.
- `hgrant` output `MASTER_NUM`: one-hot grant, registered.
- `hmaster` output 4: index of the address-phase owner, registered.
- `hmastlock` output 1: current address phase is locked, registered.

## Operation
- Reset values: `hgrant = 1<<DEFAULT_MASTER`, `hmaster = DEFAULT_MASTER`, `hmastlock = 0`, state ARB, beat counter 0, round-robin pointer `DEFAULT_MASTER`, so master 0 wins the first contention.
- `hgrant` is always exactly one-hot and never all-zero once out of reset.
- **Arbitration policy:** round-robin.
  - The search starts at (last granted index + 1) mod `MASTER_NUM` and picks the first set `hbusreq` bit.
  - When no bit is set, the winner is `DEFAULT_MASTER`.
  - Winning as the default master does not advance the pointer.
  - The pointer updates only when a requesting master wins.
- Arbitration is evaluated only on cycles with `hready=1` and in state ARB. In every other case, `hgrant` holds.
- **Address-phase ownership:** on each edge with `hready=1`:
  - `hmaster <= index(hgrant)`.
  - `hmastlock <= hlock[index(hgrant)]`.
  - With `hready=0`, both hold.
- **States:**
  - ARB: re-arbitrate each `hready` cycle.
    - → LOCKED if the winner has `hlock=1`.
    - → BURST when the owner issues NONSEQ with `hburst` in 2..7 and `hready=1`. The counter loads beats-1 (3, 7 or 15).
  - BURST: grant held. On `hready=1`:
    - SEQ decrements the counter.
    - BUSY holds it.
    - IDLE or NONSEQ terminates early → ARB, with arbitration in that same cycle.
    - SEQ with counter==1 → ARB, with arbitration in that cycle, so the new grant overlaps the last beat.
  - LOCKED: grant held while `hlock[owner]=1`, regardless of other requests or bursts. The first `hready=1` cycle with `hlock[owner]=0` → ARB with arbitration.
- SINGLE and INCR (undefined length) never enter BURST. INCR is re-arbitrable on any beat.
- `hbusreq` deasserted by the owner during BURST or LOCKED does not release the grant early. Only the termination rules above do.

## Timing
- Grant latency: a request sampled at edge t in ARB with `hready=1` gives `hgrant` at edge t+1 and `hmaster` at the first `hready=1` edge after that (t+2 with no stall).
- With all `hbusreq=0` and the bus in ARB, `hgrant = 1<<DEFAULT_MASTER` no later than 3 cycles after the requests drop.
- `hready=0` freezes `hgrant`, `hmaster`, `hmastlock`, state and counter.
- Reset assertion mid-burst or mid-lock forces all reset values immediately (asynchronous). The first arbitration is on the first edge after deassertion.
- Simultaneous lock release and new request: the release is seen and arbitration runs in the same cycle.

## Test plan
- Reset: hold `hreset=0`, `MASTER_NUM=4` -> `hgrant=4'b1000`, `hmaster=3`, `hmastlock=0`; keep all requests low for 10 cycles -> values unchanged.
- Round-robin: `hbusreq=4'b1111`, `hready=1`, `htrans=NONSEQ`, `hburst=SINGLE` each cycle -> `hgrant` sequence 0001, 0010, 0100, 1000, 0001; `hmaster` follows one cycle later.
- Fixed burst: master 1 wins and issues NONSEQ INCR4 then 3 SEQ while master 2 requests; insert one BUSY and one `hready=0` cycle -> `hgrant=0010` until the third SEQ beat, then `0100`.
- Early termination: master 0 in INCR8 issues IDLE after 2 beats while master 3 requests -> `hgrant=1000` on the next edge.
- Locked: master 2 asserts `hbusreq`+`hlock` for 6 cycles while masters 0 and 1 request -> `hgrant=0100` throughout, `hmastlock=1` from its first address phase; on `hlock` drop -> grant moves to master 0 next edge, `hmastlock=0`.
- Reset mid-burst: assert `hreset=0` during beat 2 of INCR16 -> outputs return to reset values immediately; after release, master 0 requesting -> `hgrant=0001` one edge later.
